// File: rtl/signed_calc_seq.sv
// signed_calc_seq: multi-cycle sequencer for a 4-bit two's-complement
// calculator. One 5-bit negate/add path serves add, sub and neg. Multiply
// is done by shift-add on magnitudes, and the sign is fixed up at the end.
// The result is sign-extended to 8 bits and comes with an overflow flag.
module signed_calc_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result,
    output logic       ovf,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_EXEC = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t     state_r, next_state_s;

    logic [3:0] a_r, b_r;
    logic [1:0] op_r;
    logic       sign_a_r, sign_b_r;
    logic [4:0] opa_r, opb_r;
    logic [7:0] acc_r;
    logic [1:0] cnt_r;
    logic [7:0] result_r;
    logic       ovf_r, busy_r, done_r;

    logic [4:0] a_ext_s, b_ext_s, sum_s;
    logic [7:0] pp_s, fix_val_s;
    logic       fix_ovf_s;

    // Two's-complement negate of a 5-bit value (invert + 1).
    function automatic logic [4:0] neg5(input logic [4:0] x);
        neg5 = ~x + 5'd1;
    endfunction

    // Two's-complement negate of an 8-bit value.
    function automatic logic [7:0] neg8(input logic [7:0] x);
        neg8 = ~x + 8'd1;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. Multiply stays in EXEC until the fourth iteration.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_PREP;
                else       next_state_s = ST_IDLE;
            end
            ST_PREP: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (op_r != OP_MUL)      next_state_s = ST_FIX;
                else if (cnt_r == 2'd3)  next_state_s = ST_FIX;
                else                     next_state_s = ST_EXEC;
            end
            ST_FIX:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath helpers: sign extension, the shared adder, the shifted partial
    // product, and the final sign fix-up with the 5-bit range check.
    always_comb begin
        a_ext_s   = {a_r[3], a_r};
        b_ext_s   = {b_r[3], b_r};
        sum_s     = opa_r + opb_r;
        pp_s      = {3'b000, opa_r} << cnt_r;
        if ((op_r == OP_MUL) && (sign_a_r ^ sign_b_r)) fix_val_s = neg8(acc_r);
        else                                           fix_val_s = acc_r;
        if (op_r == OP_MUL)                            fix_ovf_s = 1'b0;
        else fix_ovf_s = !((acc_r[7:3] == 5'b00000) || (acc_r[7:3] == 5'b11111));
    end

    // Operand capture, operand preparation, and the accumulate/iterate datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r      <= 4'd0;
            b_r      <= 4'd0;
            op_r     <= 2'd0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            opa_r    <= 5'd0;
            opb_r    <= 5'd0;
            acc_r    <= 8'd0;
            cnt_r    <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                    end
                end
                ST_PREP: begin
                    sign_a_r <= a_r[3];
                    sign_b_r <= b_r[3];
                    acc_r    <= 8'd0;
                    cnt_r    <= 2'd0;
                    case (op_r)
                        OP_ADD: begin opa_r <= a_ext_s;       opb_r <= b_ext_s;       end
                        OP_SUB: begin opa_r <= a_ext_s;       opb_r <= neg5(b_ext_s); end
                        OP_NEG: begin opa_r <= neg5(a_ext_s); opb_r <= 5'd0;          end
                        OP_MUL: begin
                            opa_r <= a_r[3] ? neg5(a_ext_s) : a_ext_s;
                            opb_r <= b_r[3] ? neg5(b_ext_s) : b_ext_s;
                        end
                        default: begin opa_r <= 5'd0; opb_r <= 5'd0; end
                    endcase
                end
                ST_EXEC: begin
                    if (op_r == OP_MUL) begin
                        if (opb_r[cnt_r]) acc_r <= acc_r + pp_s;
                        cnt_r <= cnt_r + 2'd1;
                    end else begin
                        acc_r <= {{3{sum_s[4]}}, sum_s};
                    end
                end
                ST_FIX:  cnt_r <= 2'd0;
                default: cnt_r <= 2'd0;
            endcase
        end
    end

    // Registered outputs: result/ovf load only on completion, done pulses once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= 8'd0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (state_r == ST_FIX);
            if (state_r == ST_FIX) begin
                result_r <= fix_val_s;
                ovf_r    <= fix_ovf_s;
            end
        end
    end

    assign result = result_r;
    assign ovf    = ovf_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_signed_calc_seq.sv
// Directed testbench for signed_calc_seq with hand-computed expectations.
module tb_signed_calc_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] result;
    logic       ovf;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_fail;

    signed_calc_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation starting just after a rising edge. The operand inputs
    // are scrambled right after acceptance. The task returns the number of
    // edges from acceptance to done (the accepting edge counts as 1), plus the
    // sampled result and ovf, and whether busy/done behaved along the way.
    task automatic run_op(input logic [1:0] o, input logic [3:0] xa, input logic [3:0] xb,
                          output int lat, output logic [7:0] res, output logic ov,
                          output logic hs_ok);
        op = o; a = xa; b = xb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~xa; b = xb + 4'd5; op = ~o;
        lat = 1;
        hs_ok = 1'b1;
        if (busy !== 1'b1 || done !== 1'b0) hs_ok = 1'b0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) hs_ok = 1'b0;
        end
        if (busy !== 1'b0) hs_ok = 1'b0;
        res = result;
        ov  = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({result, ovf, busy, done} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got result=%h ovf=%b busy=%b done=%b, want all 0",
                     result, ovf, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got busy=%b done=%b, want 0 0", i, busy, done);
            end
        end
    endtask

    task automatic test_add_sub();
        int lat; logic [7:0] r; logic v; logic h;
        run_op(2'b00, 4'd3, 4'd4, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h07 || v !== 1'b0 || lat !== 4 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL add_3_4: got r=%h ovf=%b lat=%0d hs=%b, want 07 0 4 1", r, v, lat, h);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b, want 0", done);
        end
        run_op(2'b00, 4'd7, 4'd1, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h08 || v !== 1'b1 || lat !== 4) begin
            n_fail++;
            $display("FAIL add_7_1: got r=%h ovf=%b lat=%0d, want 08 1 4", r, v, lat);
        end
        @(posedge clk); #1;
        run_op(2'b01, 4'b1000, 4'd1, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hF7 || v !== 1'b1 || lat !== 4 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_m8_1: got r=%h ovf=%b lat=%0d hs=%b, want f7 1 4 1", r, v, lat, h);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_neg();
        int lat; logic [7:0] r; logic v; logic h;
        run_op(2'b11, 4'b1000, 4'd3, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h08 || v !== 1'b1 || lat !== 4) begin
            n_fail++;
            $display("FAIL neg_m8: got r=%h ovf=%b lat=%0d, want 08 1 4", r, v, lat);
        end
        @(posedge clk); #1;
        run_op(2'b11, 4'd5, 4'b1001, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hFB || v !== 1'b0 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_5: got r=%h ovf=%b hs=%b, want fb 0 1", r, v, h);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat; logic [7:0] r; logic v; logic h;
        run_op(2'b10, 4'b1101, 4'd5, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hF1 || v !== 1'b0 || lat !== 7 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_m3_5: got r=%h ovf=%b lat=%0d hs=%b, want f1 0 7 1", r, v, lat, h);
        end
        @(posedge clk); #1;
        run_op(2'b10, 4'b1000, 4'b1000, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h40 || v !== 1'b0 || lat !== 7) begin
            n_fail++;
            $display("FAIL mul_m8_m8: got r=%h ovf=%b lat=%0d, want 40 0 7", r, v, lat);
        end
        @(posedge clk); #1;
        run_op(2'b10, 4'd7, 4'd0, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h00 || v !== 1'b0 || lat !== 7) begin
            n_fail++;
            $display("FAIL mul_7_0: got r=%h ovf=%b lat=%0d, want 00 0 7", r, v, lat);
        end
        @(posedge clk); #1;
        run_op(2'b10, 4'd6, 4'b1011, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hE2 || v !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_6_m5: got r=%h ovf=%b, want e2 0", r, v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        int lat; logic [7:0] r; logic v; logic h;
        int extra_done;
        // Start a -2 * 3 multiply by hand, then pulse start with an add while busy.
        op = 2'b10; a = 4'b1110; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        op = 2'b00; a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (result !== 8'hFA || ovf !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL busy_ignore_result: got r=%h ovf=%b wait=%0d, want fa 0 4", result, ovf, lat);
        end
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        n_cmp++;
        if (extra_done !== 0 || result !== 8'hFA) begin
            n_fail++;
            $display("FAIL busy_ignore_no_queue: got extra=%0d r=%h, want 0 fa", extra_done, result);
        end
        r = 8'h00; v = 1'b0; h = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] r; logic v; logic h;
        run_op(2'b01, 4'd2, 4'd6, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hFC || v !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL b2b_first: got r=%h ovf=%b lat=%0d, want fc 0 4", r, v, lat);
        end
        run_op(2'b00, 4'b1001, 4'b1010, lat, r, v, h);
        n_cmp++;
        if (r !== 8'hF3 || v !== 1'b1 || lat !== 4 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got r=%h ovf=%b lat=%0d hs=%b, want f3 1 4 1", r, v, lat, h);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        int lat; logic [7:0] r; logic v; logic h;
        int seen_done;
        op = 2'b10; a = 4'd3; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || result !== 8'h00 || ovf !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got busy=%b r=%h ovf=%b done=%b, want 0 00 0 0",
                     busy, result, ovf, done);
        end
        seen_done = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got activity=%0d, want 0", seen_done);
        end
        run_op(2'b00, 4'd2, 4'd2, lat, r, v, h);
        n_cmp++;
        if (r !== 8'h04 || v !== 1'b0 || lat !== 4 || h !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_add: got r=%h ovf=%b lat=%0d hs=%b, want 04 0 4 1", r, v, lat, h);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 4'd0; b = 4'd0;
        test_reset();
        test_idle();
        test_add_sub();
        test_neg();
        test_mul();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
